prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Serial boot loader upstream of the CPU: receives a framed program over an 8N1 serial line and
//  writes it into CPU RAM from address 0. Holds the CPU in reset (cpu_hold) until a frame
//  passes its checksum, then releases it. Top level ORs cpu_hold into the CPU reset and muxes
//  ld_* onto the RAM write port while cpu_hold=1.
// PARAMETERS
//  WORD_W       8    data/address width; matches CPU
//  MEM_DEPTH    32   RAM words; max frame length
//  CLK_PER_BIT  434  clock cycles per serial bit (>=4)
// PORTS
//  clock     in   1       system clock
//  reset     in   1       synchronous, active-high reset
//  rx        in   1       async serial input, idle high
//  ld_addr   out  WORD_W  RAM write address
//  ld_data   out  WORD_W  RAM write data
//  ld_we     out  1       RAM write strobe, 1-cycle pulse
//  cpu_hold  out  1       1 = keep CPU in reset
//  done      out  1       1 = last frame loaded OK
//  err       out  1       1 = last frame rejected
//  tx        out  1       echo output (see CONFIGURATION)
// BEHAVIOUR
//  Reset: cpu_hold=1, done=0, err=0, ld_we=0, ld_addr=0, ld_data=0, tx=1; FSM->HDR, rx_fsm->IDLE.
//  rx path: 2-flop synchroniser; start = falling edge in IDLE; sample at CLK_PER_BIT/2 into start
//   bit (abort to IDLE if high), then each bit centre; LSB first; stop bit sampled.
//   Stop=1 -> byte_valid 1-cycle pulse. Stop=0 -> frame_err pulse, byte dropped.
//  Frame: 0xA5, LEN, LEN data bytes, CSUM = 8-bit modulo sum of the data bytes.
//  States: HDR, LEN, DATA, CSUM, DONE, ERR.
//   HDR : byte==0xA5 -> LEN; other bytes ignored.
//   LEN : LEN==0 or LEN>MEM_DEPTH -> ERR; else cnt=LEN, addr=0, sum=0 -> DATA.
//   DATA: each byte: ld_data=byte, ld_addr=addr, ld_we=1 the cycle after byte_valid;
//         addr++, sum+=byte; last byte -> CSUM.
//   CSUM: byte==sum -> DONE; else -> ERR.
//   DONE: cpu_hold=0, done=1, err=0; byte 0xA5 -> LEN with cpu_hold=1, done=0 on the same edge.
//   ERR : cpu_hold=1, err=1, done=0; byte 0xA5 -> LEN, err=0.
//  frame_err in LEN/DATA/CSUM -> ERR. In HDR/DONE/ERR it is ignored.
//  Entering LEN from any state clears done and err. Writes from a rejected frame stay in RAM;
//   the CPU remains held.
//  Address wrap is impossible because LEN<=MEM_DEPTH is checked. Sum wraps modulo 256.
//  Reset mid-frame: immediate return to reset values; a partial rx byte is discarded.
//  Latency: ld_we asserts 1 clock after the stop-bit sample; cpu_hold falls 1 clock after the CSUM stop-bit sample.
// CONFIGURATION
//  PROG_LOADER_ECHO_EN defined: each byte_valid byte is retransmitted 8N1 on tx at CLK_PER_BIT.
//   Transmission starts the cycle after byte_valid. A byte arriving while tx is busy is not
//   echoed, and the loader FSM is unaffected.
//  Undefined: no transmitter logic; tx tied to 1.
// STRUCTURE
//  Package prog_loader_pkg: typedef enum ld_state_t {HDR,LEN,DATA,CSUM,DONE,ERR};
//   localparam SYNC_BYTE=8'hA5; typedef enum for the rx bit-state.
//  Sub-module uart_rx #(CLK_PER_BIT): rx -> byte, byte_valid, frame_err. The echo transmitter
//   stays inline under the macro.
// TESTING (CLK_PER_BIT=4, MEM_DEPTH=32)
//  1 Reset held 3 cycles, rx=1 -> cpu_hold=1, done=0, err=0, ld_we=0, tx=1.
//  2 Send A5,03,11,22,33,66 -> ld_we pulses with (0,11),(1,22),(2,33); after 66, cpu_hold=0, done=1.
//  3 Send A5,02,10,20,31 -> two writes, then err=1, cpu_hold=1; then resend A5,02,10,20,30 -> done=1.
//  4 Send A5,00 and then A5,21 -> err=1 after the LEN byte in both cases, and no ld_we pulses.
//  5 Send A5,02,10 followed by a byte with stop bit=0 -> err=1. Then 0x7E in ERR -> no change.
//  6 Assert reset mid-DATA byte -> all outputs return to reset values the next cycle; a clean
//    frame then loads OK. With PROG_LOADER_ECHO_EN: tx reproduces each byte of test 2.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {HDR, LEN, DATA, CSUM, DONE, ERR} ld_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // A frame length is usable only if it is non-zero and fits in program RAM.
  function automatic logic lenValid(input logic [7:0] len, input int depth);
    return (len != 8'd0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 serial receiver: synchronises rx, samples each bit at its centre, flags bad stop bits.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byteValid_o,
  output logic       frameErr_o
);

  localparam int CNT_W = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rx_state_t        state_q;
  logic             rxMeta_q;
  logic             rxSync_q;
  logic             rxPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             byteValid_q;
  logic             frameErr_q;

  // A falling edge on the synchronised line while idle marks a start bit; it is
  // re-checked half a bit later so that glitches fall back to idle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RX_IDLE;
      rxMeta_q    <= 1'b1;
      rxSync_q    <= 1'b1;
      rxPrev_q    <= 1'b1;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      rxMeta_q    <= rx_i;
      rxSync_q    <= rxMeta_q;
      rxPrev_q    <= rxSync_q;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rxSync_q && rxPrev_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= RX_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rxSync_q) begin
              byteValid_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o      = shift_q;
  assign byteValid_o = byteValid_q;
  assign frameErr_o  = frameErr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial boot loader: writes a checksummed frame into CPU RAM and holds the CPU until it is valid.
// Optional byte echo on tx is enabled by defining PROG_LOADER_ECHO_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int MEM_DEPTH   = 32,
  parameter int CLK_PER_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic [WORD_W-1:0] ld_addr,
  output logic [WORD_W-1:0] ld_data,
  output logic              ld_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic              tx
);

  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxFrameErr;

  uart_rx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) uRx (
    .clock_i    (clock),
    .reset_i    (reset),
    .rx_i       (rx),
    .byte_o     (rxByte),
    .byteValid_o(rxValid),
    .frameErr_o (rxFrameErr)
  );

  ld_state_t         state_q;
  logic [7:0]        cnt_q;
  logic [WORD_W-1:0] addr_q;
  logic [7:0]        sum_q;
  logic [WORD_W-1:0] ldAddr_q;
  logic [WORD_W-1:0] ldData_q;
  logic              ldWe_q;
  logic              cpuHold_q;
  logic              done_q;
  logic              err_q;

  // Line errors only matter while a frame is in flight; between frames they are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HDR;
      cnt_q     <= '0;
      addr_q    <= '0;
      sum_q     <= '0;
      ldAddr_q  <= '0;
      ldData_q  <= '0;
      ldWe_q    <= 1'b0;
      cpuHold_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ldWe_q <= 1'b0;
      if (rxFrameErr && (state_q inside {LEN, DATA, CSUM})) begin
        state_q   <= ERR;
        err_q     <= 1'b1;
        done_q    <= 1'b0;
        cpuHold_q <= 1'b1;
      end else if (rxValid) begin
        case (state_q)
          HDR, DONE, ERR: begin
            if (rxByte == SYNC_BYTE) begin
              state_q   <= LEN;
              done_q    <= 1'b0;
              err_q     <= 1'b0;
              cpuHold_q <= 1'b1;
            end
          end
          LEN: begin
            if (lenValid(rxByte, MEM_DEPTH)) begin
              cnt_q   <= rxByte;
              addr_q  <= '0;
              sum_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
          DATA: begin
            ldWe_q   <= 1'b1;
            ldData_q <= WORD_W'(rxByte);
            ldAddr_q <= addr_q;
            addr_q   <= addr_q + WORD_W'(1);
            sum_q    <= sum_q + rxByte;
            cnt_q    <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= CSUM;
            end
          end
          CSUM: begin
            if (rxByte == sum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpuHold_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

  assign ld_addr  = ldAddr_q;
  assign ld_data  = ldData_q;
  assign ld_we    = ldWe_q;
  assign cpu_hold = cpuHold_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef PROG_LOADER_ECHO_EN
  localparam int TX_CNT_W = $clog2(CLK_PER_BIT) + 1;
  localparam logic [TX_CNT_W-1:0] TX_BIT_LAST = TX_CNT_W'(CLK_PER_BIT - 1);
  localparam logic [TX_CNT_W-1:0] TX_CNT_ONE  = TX_CNT_W'(1);

  logic                txBusy_q;
  logic                tx_q;
  logic [8:0]          txShift_q;
  logic [3:0]          txBitsLeft_q;
  logic [TX_CNT_W-1:0] txCnt_q;

  // The start bit goes out on the load edge; the shifter holds data then stop.
  // Bytes arriving while a transmission is in progress are simply not echoed.
  always_ff @(posedge clock) begin
    if (reset) begin
      txBusy_q     <= 1'b0;
      tx_q         <= 1'b1;
      txShift_q    <= '1;
      txBitsLeft_q <= '0;
      txCnt_q      <= '0;
    end else if (!txBusy_q) begin
      if (rxValid) begin
        txBusy_q     <= 1'b1;
        tx_q         <= 1'b0;
        txShift_q    <= {1'b1, rxByte};
        txBitsLeft_q <= 4'd9;
        txCnt_q      <= '0;
      end
    end else if (txCnt_q == TX_BIT_LAST) begin
      txCnt_q <= '0;
      if (txBitsLeft_q == 4'd0) begin
        txBusy_q <= 1'b0;
      end else begin
        tx_q         <= txShift_q[0];
        txShift_q    <= {1'b1, txShift_q[8:1]};
        txBitsLeft_q <= txBitsLeft_q - 4'd1;
      end
    end else begin
      txCnt_q <= txCnt_q + TX_CNT_ONE;
    end
  end

  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule
